// File: rtl/bus_demux4.sv
// bus_demux4 -- 1-to-4 write-path routing demultiplexer.
//
// One input stream (valid/ready, 2-bit destination select) is steered to one
// of four output channels a..d. Each channel holds one word in a register with
// its own valid/ready handshake, so a stalled destination blocks the input only
// while it is the selected one.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   in_sel              destination: 0=a, 1=b, 2=c, 3=d
//   in_data             input word
//   out_valid/out_ready per-channel handshake, bit0=a .. bit3=d
//   out_data_a..d       per-channel held word
//   cnt_a..d            per-channel saturating handshake counters
//                       (present only when DEMUX4_CNT_EN is defined)
//
// Optional feature macro: DEMUX4_CNT_EN

// One output channel: single-entry holding register plus EMPTY/FULL state.
module bus_demux4_chan #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,       // word accepted for this channel
  input  logic [DW-1:0] load_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data
`ifdef DEMUX4_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      EMPTY: begin
        if (load) begin
          state_d = FULL;
          data_d  = load_data;
        end
      end
      FULL: begin
        // A load while FULL only happens when out_ready is high (the input
        // side gates on it), so reload implies the held word drained.
        if (load) begin
          data_d = load_data;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;

`ifdef DEMUX4_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count output handshakes, sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
`endif
endmodule

module bus_demux4 #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_sel,
  input  logic [DW-1:0] in_data,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [DW-1:0] out_data_a,
  output logic [DW-1:0] out_data_b,
  output logic [DW-1:0] out_data_c,
  output logic [DW-1:0] out_data_d
`ifdef DEMUX4_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c,
  output logic [CNT_W-1:0] cnt_d
`endif
);
  logic                 accept;
  logic [3:0]           load;
  logic [3:0][DW-1:0]   data_w;

  // Ready depends only on the selected channel: free, or draining this cycle.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;

`ifdef DEMUX4_CNT_EN
  logic [3:0][CNT_W-1:0] cnt_w;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_chan
    assign load[g] = accept & (in_sel == 2'(g));

    bus_demux4_chan #(.DW(DW), .CNT_W(CNT_W)) u_chan (
      .clk       (clk),
      .rst       (rst),
      .load      (load[g]),
      .load_data (in_data),
      .out_ready (out_ready[g]),
      .out_valid (out_valid[g]),
      .out_data  (data_w[g])
`ifdef DEMUX4_CNT_EN
      ,
      .cnt       (cnt_w[g])
`endif
    );
  end

  assign out_data_a = data_w[0];
  assign out_data_b = data_w[1];
  assign out_data_c = data_w[2];
  assign out_data_d = data_w[3];

`ifdef DEMUX4_CNT_EN
  assign cnt_a = cnt_w[0];
  assign cnt_b = cnt_w[1];
  assign cnt_c = cnt_w[2];
  assign cnt_d = cnt_w[3];
`endif
endmodule

// File: tb/tb_bus_demux4.sv
module tb_bus_demux4;
  localparam int DW = 32;
`ifdef DEMUX4_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_sel;
  logic [DW-1:0] in_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [DW-1:0] out_data_a, out_data_b, out_data_c, out_data_d;
`ifdef DEMUX4_CNT_EN
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c, cnt_d;
`endif

  int checks;
  int errors;

  bus_demux4 #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data_a (out_data_a),
    .out_data_b (out_data_b),
    .out_data_c (out_data_c),
    .out_data_d (out_data_d)
`ifdef DEMUX4_CNT_EN
    ,
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b),
    .cnt_c      (cnt_c),
    .cnt_d      (cnt_d)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] chan_data(input int k);
    case (k)
      0:       return out_data_a;
      1:       return out_data_b;
      2:       return out_data_c;
      default: return out_data_d;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;
    #2; // before any clock edge
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_valid: got %b expected 0000", out_valid);
    end
    checks++;
    if ({out_data_a, out_data_b, out_data_c, out_data_d} !== '0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h expected all 0",
                         out_data_a, out_data_b, out_data_c, out_data_d);
    end
    step(); step();
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL reset_in_ready sel=%0d: got %b expected 1", s, in_ready);
      end
    end
  endtask

  task automatic test_basic();
    out_ready = 4'b1111;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEADBEEF;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0100 || out_data_c !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_route: got valid=%b c=%h expected 0100 deadbeef",
                         out_valid, out_data_c);
    end
    step();
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL basic_drain: got %b expected 0000", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1110;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h1;
    step();
    in_data = 32'h2;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_in_ready_stall: got %b expected 0", in_ready);
    end
    step();
    checks++;
    if (out_valid[0] !== 1'b1 || out_data_a !== 32'h1) begin
      errors++; $display("FAIL bp_hold: got valid=%b a=%h expected 1 00000001",
                         out_valid[0], out_data_a);
    end
    out_ready[0] = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_in_ready_release: got %b expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b1 || out_data_a !== 32'h2) begin
      errors++; $display("FAIL bp_reload: got valid=%b a=%h expected 1 00000002",
                         out_valid[0], out_data_a);
    end
    step();
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL bp_drain: got %b expected 0000", out_valid);
    end
  endtask

  task automatic test_independence();
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h55;
    step();
    in_sel = 2'd3; in_data = 32'h33;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL indep_in_ready: got %b expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b1010 || out_data_b !== 32'h55 || out_data_d !== 32'h33) begin
      errors++; $display("FAIL indep_state: got valid=%b b=%h d=%h expected 1010 55 33",
                         out_valid, out_data_b, out_data_d);
    end
    in_sel = 2'd1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL indep_stalled_sel: got %b expected 0", in_ready);
    end
    out_ready = 4'b1111;
    step();
    checks++;
    if (out_valid !== 4'b0000 || out_data_b !== 32'h55) begin
      errors++; $display("FAIL indep_drain: got valid=%b b=%h expected 0000 55",
                         out_valid, out_data_b);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words [4];
    words[0] = 32'hA0; words[1] = 32'hB1; words[2] = 32'hC2; words[3] = 32'hD3;
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = 2'(k); in_data = words[k];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", k, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 4'(1 << k) || chan_data(k) !== words[k]) begin
        errors++; $display("FAIL b2b_out[%0d]: got valid=%b data=%h expected %b %h",
                           k, out_valid, chan_data(k), 4'(1 << k), words[k]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL b2b_drain: got %b expected 0000", out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h11;
    step();
    in_sel = 2'd2; in_data = 32'h22;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0101) begin
      errors++; $display("FAIL areset_pre: got %b expected 0101", out_valid);
    end
    #2;
    rst = 1'b1;  // mid-cycle, no edge
    #1;
    checks++;
    if (out_valid !== 4'b0000 || out_data_a !== '0 || out_data_c !== '0) begin
      errors++; $display("FAIL areset_immediate: got valid=%b a=%h c=%h expected 0000 0 0",
                         out_valid, out_data_a, out_data_c);
    end
    step();
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL areset_in_ready sel=%0d: got %b expected 1", s, in_ready);
      end
    end
  endtask

`ifdef DEMUX4_CNT_EN
  task automatic test_counters();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    checks++;
    if ({cnt_a, cnt_b, cnt_c, cnt_d} !== '0) begin
      errors++; $display("FAIL cnt_reset: got %h %h %h %h expected all 0",
                         cnt_a, cnt_b, cnt_c, cnt_d);
    end
    out_ready = 4'b1111;
    for (int k = 0; k < 23; k++) begin
      in_valid = 1'b1;
      in_sel   = (k < 20) ? 2'd1 : 2'd0;
      in_data  = 32'(k);
      step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (cnt_b !== 4'hF) begin
      errors++; $display("FAIL cnt_b_sat: got %h expected f", cnt_b);
    end
    checks++;
    if (cnt_a !== 4'd3) begin
      errors++; $display("FAIL cnt_a: got %h expected 3", cnt_a);
    end
    checks++;
    if (cnt_c !== 4'd0 || cnt_d !== 4'd0) begin
      errors++; $display("FAIL cnt_cd: got %h %h expected 0 0", cnt_c, cnt_d);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_independence();
    test_back_to_back();
    test_async_reset();
`ifdef DEMUX4_CNT_EN
    test_counters();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_demux4.md
Name: bus_demux4

Overview:
- 1-to-4 routing demultiplexer: the write-side counterpart of the SoC's 4:1 read-data selector.
- Accepts one data stream with a 2-bit destination select and delivers each word to one of four independent output channels (a, b, c, d).
- Each output channel has a one-entry holding register with a valid/ready handshake, so a stalled destination never corrupts or drops data.
- Sits between the CPU/bus master write port and four peripheral/slave write ports.

Parameters:
- DW, 32, data width of input and all output channels.
- CNT_W, 16, width of per-channel transfer counters (used only with DEMUX4_CNT_EN).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  input word accepted this cycle when in_valid is also high.
- in_sel  input  2  destination: 00 = a, 01 = b, 10 = c, 11 = d.
- in_data  input  DW  input word.
- out_valid  output  4  per-channel valid; bit0 = a, bit1 = b, bit2 = c, bit3 = d.
- out_ready  input  4  per-channel ready; same bit mapping as out_valid.
- out_data_a  output  DW  channel a word.
- out_data_b  output  DW  channel b word.
- out_data_c  output  DW  channel c word.
- out_data_d  output  DW  channel d word.

Behaviour:
- Reset (asynchronous, immediate on rst high, no clock edge needed): out_valid = 4'b0000; out_data_a/b/c/d = 0; counters = 0.
- Per-channel state machine, one per channel i:
  - EMPTY (out_valid[i] = 0) -> FULL when a word is accepted with in_sel = i.
  - FULL -> EMPTY when out_ready[i] = 1 and no new word for i is accepted that cycle.
  - FULL -> FULL (reloaded) when out_ready[i] = 1 and a word for i is accepted in the same cycle.
- in_ready is combinational: in_ready = ~out_valid[in_sel] | out_ready[in_sel]. It reflects only the selected channel, and is valid whether or not in_valid is high.
- accept = in_valid & in_ready. On accept, the selected channel loads in_data and sets out_valid on the next rising edge.
- Latency: input to output is 1 cycle. Throughput: 1 word/cycle per channel while its out_ready is held high.
- Unselected channels: data and valid are unchanged by input activity; they drain only via their own out_ready.
- While out_valid[i] = 1 and out_ready[i] = 0, out_data_i is held stable.
- Channels are independent: a stall on channel i blocks the input only while in_sel = i.
- out_data_i after a drain keeps its last value; it is don't-care while out_valid[i] = 0 and need not be cleared.
- Words are never dropped or duplicated.
- Reset asserted mid-stall discards all held words. in_ready after reset = 1 for any in_sel.

Optional Feature:
- Macro: DEMUX4_CNT_EN.
- Defined: adds output ports cnt_a, cnt_b, cnt_c, cnt_d (each CNT_W bits).
  - Each counter increments on its channel's output handshake (out_valid[i] & out_ready[i]).
  - Counters saturate at all-ones and reset to 0.
- Undefined: no counter ports and no counter logic; all other behaviour is identical.

Test Plan:
- Basic routing: after reset, out_ready = 4'b1111; send in_sel = 10, in_data = 0xDEADBEEF for one cycle -> next cycle out_valid = 4'b0100, out_data_c = 0xDEADBEEF; the cycle after, out_valid = 0.
- Backpressure: out_ready[0] = 0; send 0x00000001 then 0x00000002, both to a -> first accepted; in_ready = 0 on the second; out_data_a holds 0x1. Raise out_ready[0] -> 0x2 accepted that same cycle and out_data_a = 0x2 on the next cycle, with out_valid[0] staying 1.
- Independence: channel b full and stalled (out_ready[1] = 0); send 0x33 to d -> in_ready = 1, out_valid = 4'b1010, out_data_b unchanged.
- Back-to-back: 4 consecutive words 0xA0, 0xB1, 0xC2, 0xD3 with in_sel = 0, 1, 2, 3 and all ready -> in_ready stays 1 throughout; each word appears on its channel exactly one cycle after acceptance.
- Async reset: channels a and c full and stalled; assert rst between clock edges -> out_valid = 0 immediately; after release, in_ready = 1 for all in_sel.
- Counters (DEMUX4_CNT_EN, CNT_W = 4): 20 handshakes on channel b and 3 on channel a -> cnt_b = 4'hF (saturated), cnt_a = 3, cnt_c = cnt_d = 0.
